// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//  Shares the single-port vector data RAM between the core MEM stage and a
//  host/debug port. The core normally wins. A starvation counter forces a
//  bounded host slot, and the core is stalled during that slot. Read data is
//  returned to the owner of the grant one cycle later.
module dmem_arbiter #(
    parameter int MEM_WA       = 8,
    parameter int WIDTH_VECTOR = 8,
    parameter int N            = 32,
    parameter int MAX_STARVE   = 16,
    parameter int HOST_BURST   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    // core MEM-stage side
    input  logic                      core_req,
    input  logic                      core_we,
    input  logic [MEM_WA-1:0]         core_addr,
    input  logic [WIDTH_VECTOR*N-1:0] core_wdata,
    output logic                      core_gnt,
    output logic                      core_stall,
    output logic                      core_rvalid,
    output logic [WIDTH_VECTOR*N-1:0] core_rdata,
    // host/debug side
    input  logic                      host_req,
    input  logic                      host_we,
    input  logic [MEM_WA-1:0]         host_addr,
    input  logic [WIDTH_VECTOR*N-1:0] host_wdata,
    output logic                      host_gnt,
    output logic                      host_rvalid,
    output logic [WIDTH_VECTOR*N-1:0] host_rdata,
    // RAM side
    output logic [MEM_WA-1:0]         ram_addr,
    output logic                      ram_we,
    output logic [WIDTH_VECTOR*N-1:0] ram_wdata,
    input  logic [WIDTH_VECTOR*N-1:0] ram_rdata
);

    localparam int DW = WIDTH_VECTOR * N;
    localparam int SW = $clog2(MAX_STARVE + 1);
    localparam int BW = $clog2(HOST_BURST + 1);

    localparam logic [SW-1:0] STARVE_LAST = SW'(MAX_STARVE - 1);
    localparam logic [SW-1:0] STARVE_SAT  = SW'(MAX_STARVE);
    localparam logic [SW-1:0] STARVE_ONE  = SW'(1);
    localparam logic [SW-1:0] STARVE_ZERO = SW'(0);
    localparam logic [BW-1:0] BURST_LAST  = BW'(HOST_BURST - 1);
    localparam logic [BW-1:0] BURST_ONE   = BW'(1);
    localparam logic [BW-1:0] BURST_ZERO  = BW'(0);

    typedef enum logic {
        ST_CORE_PRI  = 1'b0,
        ST_HOST_SLOT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CORE = 2'd1,
        TAG_HOST = 2'd2
    } tag_t;

    state_t          state_r;
    logic [SW-1:0]   starve_cnt_r;
    logic [BW-1:0]   burst_cnt_r;
    tag_t            rd_tag_r;

    logic            core_gnt_s;
    logic            host_gnt_s;
    logic            host_loss_s;
    tag_t            rd_tag_nxt_s;

    // Grant decision from the registered state and the live requests; nothing is granted while in reset.
    always_comb begin
        core_gnt_s = 1'b0;
        host_gnt_s = 1'b0;
        if (rst) begin
            core_gnt_s = 1'b0;
            host_gnt_s = 1'b0;
        end else begin
            case (state_r)
                ST_CORE_PRI: begin
                    core_gnt_s = core_req;
                    host_gnt_s = host_req & ~core_req;
                end
                ST_HOST_SLOT: begin
                    core_gnt_s = 1'b0;
                    host_gnt_s = host_req;
                end
                default: begin
                    core_gnt_s = 1'b0;
                    host_gnt_s = 1'b0;
                end
            endcase
        end
    end

    assign host_loss_s = host_req & ~host_gnt_s;

    // RAM port mux: the granted side owns the RAM; an idle cycle parks everything at zero.
    always_comb begin
        ram_addr  = {MEM_WA{1'b0}};
        ram_we    = 1'b0;
        ram_wdata = {DW{1'b0}};
        if (core_gnt_s) begin
            ram_addr  = core_addr;
            ram_we    = core_we;
            ram_wdata = core_wdata;
        end else if (host_gnt_s) begin
            ram_addr  = host_addr;
            ram_we    = host_we;
            ram_wdata = host_wdata;
        end else begin
            ram_addr  = {MEM_WA{1'b0}};
            ram_we    = 1'b0;
            ram_wdata = {DW{1'b0}};
        end
    end

    // Owner tag for the read beat issued this cycle; writes and idle cycles carry no tag.
    always_comb begin
        rd_tag_nxt_s = TAG_NONE;
        if (core_gnt_s && !core_we) begin
            rd_tag_nxt_s = TAG_CORE;
        end else if (host_gnt_s && !host_we) begin
            rd_tag_nxt_s = TAG_HOST;
        end else begin
            rd_tag_nxt_s = TAG_NONE;
        end
    end

    // Arbitration FSM with starvation and burst counters plus the read-return tag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_CORE_PRI;
            starve_cnt_r <= STARVE_ZERO;
            burst_cnt_r  <= BURST_ZERO;
            rd_tag_r     <= TAG_NONE;
        end else begin
            rd_tag_r <= rd_tag_nxt_s;
            case (state_r)
                ST_CORE_PRI: begin
                    if (host_loss_s) begin
                        if (starve_cnt_r == STARVE_LAST) begin
                            // host has lost MAX_STARVE cycles in a row: hand it the bus
                            state_r      <= ST_HOST_SLOT;
                            starve_cnt_r <= STARVE_ZERO;
                            burst_cnt_r  <= BURST_ZERO;
                        end else if (starve_cnt_r != STARVE_SAT) begin
                            starve_cnt_r <= starve_cnt_r + STARVE_ONE;
                        end else begin
                            starve_cnt_r <= starve_cnt_r;
                        end
                    end else begin
                        // host either got the bus or stopped asking
                        starve_cnt_r <= STARVE_ZERO;
                    end
                end
                ST_HOST_SLOT: begin
                    if (!host_req) begin
                        // host gave up early: core regains the bus next cycle
                        state_r <= ST_CORE_PRI;
                    end else if (host_gnt_s) begin
                        if (burst_cnt_r == BURST_LAST) begin
                            state_r <= ST_CORE_PRI;
                        end else begin
                            burst_cnt_r <= burst_cnt_r + BURST_ONE;
                        end
                    end else begin
                        burst_cnt_r <= burst_cnt_r;
                    end
                end
                default: begin
                    state_r      <= ST_CORE_PRI;
                    starve_cnt_r <= STARVE_ZERO;
                    burst_cnt_r  <= BURST_ZERO;
                end
            endcase
        end
    end

    assign core_gnt    = core_gnt_s;
    assign host_gnt    = host_gnt_s;
    assign core_stall  = core_req & ~core_gnt_s;

    assign core_rvalid = (rd_tag_r == TAG_CORE);
    assign host_rvalid = (rd_tag_r == TAG_HOST);
    assign core_rdata  = core_rvalid ? ram_rdata : {DW{1'b0}};
    assign host_rdata  = host_rvalid ? ram_rdata : {DW{1'b0}};

endmodule
